// File: rtl/mc_mainfsm.sv
// Main control FSM for a multicycle RV32 core: sequences fetch, decode and
// execute steps and drives the datapath mux selects and write enables.
module mc_mainfsm #(
  parameter bit EXT_U    = 1'b1,
  parameter bit EXT_JALR = 1'b1,
  parameter bit MEM_WAIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    JALR     = 4'd11,
    LUI      = 4'd12,
    TRAP     = 4'd13
  } state_e;

  state_e state_q;
  state_e state_d;

  // Without the wait handshake every memory state completes in one cycle.
  logic mem_go;
  assign mem_go = MEM_WAIT ? mem_ready : 1'b1;

  function automatic state_e decode_op(input logic [6:0] opc);
    state_e nxt;
    case (opc)
      OP_LOAD, OP_STORE: nxt = MEMADR;
      OP_REG:            nxt = EXECR;
      OP_IMM:            nxt = EXECI;
      OP_BRANCH:         nxt = BRANCH;
      OP_JAL:            nxt = JAL;
      OP_JALR:           nxt = EXT_JALR ? JALR  : TRAP;
      OP_LUI:            nxt = EXT_U    ? LUI   : TRAP;
      OP_AUIPC:          nxt = EXT_U    ? ALUWB : TRAP;
      default:           nxt = TRAP;
    endcase
    return nxt;
  endfunction

  function automatic logic [2:0] imm_sel(input logic [6:0] opc);
    logic [2:0] sel;
    case (opc)
      OP_LOAD, OP_IMM, OP_JALR: sel = 3'b000;
      OP_STORE:                 sel = 3'b001;
      OP_BRANCH:                sel = 3'b010;
      OP_JAL:                   sel = 3'b011;
      OP_LUI, OP_AUIPC:         sel = 3'b100;
      default:                  sel = 3'b000;
    endcase
    return sel;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (mem_go) state_d = DECODE;
      DECODE:   state_d = decode_op(op);
      MEMADR:   state_d = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (mem_go) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: if (mem_go) state_d = FETCH;
      EXECR:    state_d = ALUWB;
      EXECI:    state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = FETCH;
      JAL:      state_d = ALUWB;
      JALR:     state_d = JAL;
      LUI:      state_d = ALUWB;
      TRAP:     state_d = TRAP;
      default:  state_d = FETCH;
    endcase
  end

  logic       rw_m, mw_m, ir_m, pc_m, br_m, done_m, ill_m, adr_m;
  logic [1:0] srca_m, srcb_m, res_m, aluop_m;

  always_comb begin
    rw_m    = 1'b0;
    mw_m    = 1'b0;
    ir_m    = 1'b0;
    pc_m    = 1'b0;
    br_m    = 1'b0;
    done_m  = 1'b0;
    ill_m   = 1'b0;
    adr_m   = 1'b0;
    srca_m  = 2'b00;
    srcb_m  = 2'b00;
    res_m   = 2'b00;
    aluop_m = 2'b00;
    case (state_q)
      FETCH: begin
        ir_m   = mem_go;
        pc_m   = mem_go;
        srcb_m = 2'b10;
        res_m  = 2'b10;
      end
      DECODE: begin
        srca_m = 2'b01;
        srcb_m = 2'b01;
      end
      MEMADR: begin
        srca_m = 2'b10;
        srcb_m = 2'b01;
      end
      MEMREAD: adr_m = 1'b1;
      MEMWB: begin
        res_m  = 2'b01;
        rw_m   = 1'b1;
        done_m = 1'b1;
      end
      // MemWrite stays up through a stall; completion only when memory accepts.
      MEMWRITE: begin
        adr_m  = 1'b1;
        mw_m   = 1'b1;
        done_m = mem_go;
      end
      EXECR: begin
        srca_m  = 2'b10;
        aluop_m = 2'b10;
      end
      EXECI: begin
        srca_m  = 2'b10;
        srcb_m  = 2'b01;
        aluop_m = 2'b10;
      end
      ALUWB: begin
        rw_m   = 1'b1;
        done_m = 1'b1;
      end
      BRANCH: begin
        srca_m  = 2'b10;
        aluop_m = 2'b01;
        br_m    = 1'b1;
        done_m  = 1'b1;
      end
      JAL: begin
        srca_m = 2'b01;
        srcb_m = 2'b10;
        pc_m   = 1'b1;
      end
      JALR: begin
        srca_m = 2'b10;
        srcb_m = 2'b01;
      end
      LUI: begin
        srca_m = 2'b11;
        srcb_m = 2'b01;
      end
      TRAP:    ill_m = 1'b1;
      default: ill_m = 1'b0;
    endcase
  end

  // Reset parks the state in FETCH, so enables are masked until rst_n rises.
  assign RegWrite   = rw_m   & rst_n;
  assign MemWrite   = mw_m   & rst_n;
  assign IRWrite    = ir_m   & rst_n;
  assign PCUpdate   = pc_m   & rst_n;
  assign Branch     = br_m   & rst_n;
  assign instr_done = done_m & rst_n;
  assign illegal    = ill_m  & rst_n;
  assign AdrSrc     = adr_m;
  assign ALUSrcA    = srca_m;
  assign ALUSrcB    = srcb_m;
  assign ResultSrc  = res_m;
  assign ALUOp      = aluop_m;
  assign ImmSrc     = imm_sel(op);

endmodule

// File: tb/tb_mc_mainfsm.sv
// Directed bench for mc_mainfsm: a default instance (no memory wait) and a
// MEM_WAIT=1 instance with both extensions disabled.
module tb_mc_mainfsm;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2,
                         S_MEMREAD = 4'd3, S_MEMWB = 4'd4, S_MEMWRITE = 4'd5,
                         S_EXECR = 4'd6, S_EXECI = 4'd7, S_ALUWB = 4'd8,
                         S_BRANCH = 4'd9, S_JAL = 4'd10, S_JALR = 4'd11,
                         S_LUI = 4'd12, S_TRAP = 4'd13;

  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011,
                         OP_R = 7'b0110011, OP_I = 7'b0010011,
                         OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111,
                         OP_AUIPC = 7'b0010111, OP_BAD = 7'b1111111;

  logic       clk;
  logic       rst0_n, rst1_n;
  logic [6:0] op0, op1;
  logic       mr0, mr1;

  logic       rw0, mw0, ir0, pc0, br0, ad0, dn0, il0;
  logic [1:0] sa0, sb0, rs0, ao0;
  logic [2:0] im0;
  logic       rw1, mw1, ir1, pc1, br1, ad1, dn1, il1;
  logic [1:0] sa1, sb1, rs1, ao1;
  logic [2:0] im1;

  int n_chk = 0;
  int n_err = 0;

  mc_mainfsm dut0 (
    .clk(clk), .rst_n(rst0_n), .op(op0), .mem_ready(mr0),
    .RegWrite(rw0), .MemWrite(mw0), .IRWrite(ir0), .PCUpdate(pc0),
    .Branch(br0), .AdrSrc(ad0), .ALUSrcA(sa0), .ALUSrcB(sb0),
    .ResultSrc(rs0), .ALUOp(ao0), .ImmSrc(im0), .instr_done(dn0),
    .illegal(il0)
  );

  mc_mainfsm #(.EXT_U(1'b0), .EXT_JALR(1'b0), .MEM_WAIT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .op(op1), .mem_ready(mr1),
    .RegWrite(rw1), .MemWrite(mw1), .IRWrite(ir1), .PCUpdate(pc1),
    .Branch(br1), .AdrSrc(ad1), .ALUSrcA(sa1), .ALUSrcB(sb1),
    .ResultSrc(rs1), .ALUOp(ao1), .ImmSrc(im1), .instr_done(dn1),
    .illegal(il1)
  );

  logic [15:0] v0, v1;
  logic [6:0]  en0, en1;
  assign v0  = {rw0, mw0, ir0, pc0, br0, ad0, sa0, sb0, rs0, ao0, dn0, il0};
  assign v1  = {rw1, mw1, ir1, pc1, br1, ad1, sa1, sb1, rs1, ao1, dn1, il1};
  assign en0 = {rw0, mw0, ir0, pc0, br0, dn0, il0};
  assign en1 = {rw1, mw1, ir1, pc1, br1, dn1, il1};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected Moore outputs, packed as v0/v1, for an ungated state.
  function automatic logic [15:0] exp_out(input logic [3:0] s);
    logic rw, mw, ir, pc, br, ad, dn, il;
    logic [1:0] a, b, r, o;
    {rw, mw, ir, pc, br, ad, dn, il} = 8'b0;
    a = 2'b00; b = 2'b00; r = 2'b00; o = 2'b00;
    case (s)
      S_FETCH:    begin ir = 1; pc = 1; b = 2'b10; r = 2'b10; end
      S_DECODE:   begin a = 2'b01; b = 2'b01; end
      S_MEMADR:   begin a = 2'b10; b = 2'b01; end
      S_MEMREAD:  begin ad = 1; end
      S_MEMWB:    begin r = 2'b01; rw = 1; dn = 1; end
      S_MEMWRITE: begin ad = 1; mw = 1; dn = 1; end
      S_EXECR:    begin a = 2'b10; o = 2'b10; end
      S_EXECI:    begin a = 2'b10; b = 2'b01; o = 2'b10; end
      S_ALUWB:    begin rw = 1; dn = 1; end
      S_BRANCH:   begin a = 2'b10; o = 2'b01; br = 1; dn = 1; end
      S_JAL:      begin a = 2'b01; b = 2'b10; pc = 1; end
      S_JALR:     begin a = 2'b10; b = 2'b01; end
      S_LUI:      begin a = 2'b11; b = 2'b01; end
      S_TRAP:     begin il = 1; end
      default:    begin il = 0; end
    endcase
    return {rw, mw, ir, pc, br, ad, a, b, r, o, dn, il};
  endfunction

  // Called at a falling edge with dut0 in FETCH; walks one instruction.
  task automatic run_instr(input string tag, input logic [6:0] opc, input int n,
                           input logic [3:0] seq [5], input logic [2:0] imm);
    for (int i = 0; i < n; i++) begin
      op0 = opc;
      mr0 = i[0];
      #1;
      check($sformatf("%s[%0d]", tag, i), {16'h0, v0}, {16'h0, exp_out(seq[i])});
      if (i == 0) check({tag, "_imm"}, {29'h0, im0}, {29'h0, imm});
      @(negedge clk);
    end
  endtask

  task automatic step1(input string tag, input logic [6:0] opc, input logic mr,
                       input logic [15:0] exp);
    op1 = opc;
    mr1 = mr;
    #1;
    check(tag, {16'h0, v1}, {16'h0, exp});
    @(negedge clk);
  endtask

  initial begin
    rst0_n = 1'b0; rst1_n = 1'b0;
    op0 = 7'h0; op1 = 7'h0; mr0 = 1'b0; mr1 = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst0_en", {25'h0, en0}, 32'h0);
    check("rst1_en", {25'h0, en1}, 32'h0);
    @(negedge clk);

    rst0_n = 1'b1;
    run_instr("lw",    OP_LW,    5, '{S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB}, 3'b000);
    run_instr("sw",    OP_SW,    4, '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWRITE, S_FETCH}, 3'b001);
    run_instr("rtype", OP_R,     4, '{S_FETCH, S_DECODE, S_EXECR, S_ALUWB, S_FETCH}, 3'b000);
    run_instr("itype", OP_I,     4, '{S_FETCH, S_DECODE, S_EXECI, S_ALUWB, S_FETCH}, 3'b000);
    run_instr("br",    OP_BR,    3, '{S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_FETCH}, 3'b010);
    run_instr("jal",   OP_JAL,   4, '{S_FETCH, S_DECODE, S_JAL, S_ALUWB, S_FETCH}, 3'b011);
    run_instr("jalr",  OP_JALR,  5, '{S_FETCH, S_DECODE, S_JALR, S_JAL, S_ALUWB}, 3'b000);
    run_instr("lui",   OP_LUI,   4, '{S_FETCH, S_DECODE, S_LUI, S_ALUWB, S_FETCH}, 3'b100);
    run_instr("auipc", OP_AUIPC, 3, '{S_FETCH, S_DECODE, S_ALUWB, S_FETCH, S_FETCH}, 3'b100);
    run_instr("bad",   OP_BAD,   3, '{S_FETCH, S_DECODE, S_TRAP, S_FETCH, S_FETCH}, 3'b000);
    for (int i = 0; i < 5; i++) begin
      op0 = OP_LW;
      #1;
      check($sformatf("trap0_hold[%0d]", i), {16'h0, v0}, {16'h0, exp_out(S_TRAP)});
      @(negedge clk);
    end
    rst0_n = 1'b0;
    #1;
    check("trap0_rst_en", {25'h0, en0}, 32'h0);
    @(negedge clk);
    rst0_n = 1'b1;
    run_instr("post_rst0", OP_I, 4, '{S_FETCH, S_DECODE, S_EXECI, S_ALUWB, S_FETCH}, 3'b000);

    rst1_n = 1'b1;
    step1("f_stall0", OP_SW, 1'b0, exp_out(S_FETCH) & 16'hCFFF);
    step1("f_stall1", OP_SW, 1'b0, exp_out(S_FETCH) & 16'hCFFF);
    step1("f_go",     OP_SW, 1'b1, exp_out(S_FETCH));
    check("sw1_imm", {29'h0, im1}, 32'h1);
    step1("sw1_dec",  OP_SW, 1'b0, exp_out(S_DECODE));
    step1("sw1_adr",  OP_SW, 1'b0, exp_out(S_MEMADR));
    for (int i = 0; i < 3; i++)
      step1($sformatf("sw1_wait[%0d]", i), OP_SW, 1'b0, exp_out(S_MEMWRITE) & 16'hFFFD);
    step1("sw1_done", OP_SW, 1'b1, exp_out(S_MEMWRITE));

    step1("lw1_f",     OP_LW, 1'b1, exp_out(S_FETCH));
    step1("lw1_dec",   OP_LW, 1'b0, exp_out(S_DECODE));
    step1("lw1_adr",   OP_LW, 1'b0, exp_out(S_MEMADR));
    step1("lw1_rwait", OP_LW, 1'b0, exp_out(S_MEMREAD));
    step1("lw1_rgo",   OP_LW, 1'b1, exp_out(S_MEMREAD));
    step1("lw1_wb",    OP_LW, 1'b0, exp_out(S_MEMWB));

    step1("lui1_f",   OP_LUI, 1'b1, exp_out(S_FETCH));
    step1("lui1_dec", OP_LUI, 1'b1, exp_out(S_DECODE));
    for (int i = 0; i < 10; i++)
      step1($sformatf("lui1_trap[%0d]", i), (i < 5) ? OP_LUI : OP_R, i[0], exp_out(S_TRAP));
    rst1_n = 1'b0;
    #1;
    check("trap1_rst_en", {25'h0, en1}, 32'h0);
    @(negedge clk);
    rst1_n = 1'b1;

    step1("jalr1_f",    OP_JALR, 1'b1, exp_out(S_FETCH));
    step1("jalr1_dec",  OP_JALR, 1'b1, exp_out(S_DECODE));
    step1("jalr1_trap", OP_JALR, 1'b1, exp_out(S_TRAP));
    rst1_n = 1'b0;
    @(negedge clk);
    rst1_n = 1'b1;

    step1("ar_f",   OP_SW, 1'b1, exp_out(S_FETCH));
    step1("ar_dec", OP_SW, 1'b1, exp_out(S_DECODE));
    step1("ar_adr", OP_SW, 1'b1, exp_out(S_MEMADR));
    op1 = OP_SW;
    mr1 = 1'b0;
    #1;
    check("ar_mw_before", {31'h0, mw1}, 32'h1);
    #2;
    rst1_n = 1'b0;
    #1;
    check("ar_mw_after", {31'h0, mw1}, 32'h0);
    check("ar_en_after", {25'h0, en1}, 32'h0);
    @(negedge clk);
    rst1_n = 1'b1;
    mr1 = 1'b1;
    #1;
    check("ar_irw", {31'h0, ir1}, 32'h1);
    @(negedge clk);
    step1("ar_dec2", OP_SW, 1'b1, exp_out(S_DECODE));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mc_mainfsm.md
MC_MAINFSM -- requirements
Module: mc_mainfsm

Interface
REQ-001 Parameters SHALL be: EXT_U, default 1, enables lui/auipc; EXT_JALR, default 1, enables jalr; MEM_WAIT, default 0, enables the mem_ready stall handshake.
REQ-002 Ports SHALL be (name direction width meaning), clock and reset first: clk in 1 clock; rst_n in 1 reset; op in 7 opcode from instruction register; mem_ready in 1 memory access complete; RegWrite out 1; MemWrite out 1; IRWrite out 1; PCUpdate out 1; Branch out 1; AdrSrc out 1 (0 PC, 1 ALUOut); ALUSrcA out 2 (00 PC, 01 OldPC, 10 rs1, 11 zero); ALUSrcB out 2 (00 rs2, 01 imm, 10 const 4); ResultSrc out 2 (00 ALUOut, 01 Data, 10 ALUResult); ALUOp out 2; ImmSrc out 3; instr_done out 1; illegal out 1.
REQ-003 The block SHALL use one clock, clk; reset rst_n SHALL be asynchronous and active-low.

Function
REQ-004 States SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, LUI, TRAP; 4-bit encoding; state register only sequential element.
REQ-005 Control outputs SHALL be Moore (state decode only); unlisted outputs 0.
REQ-006 FETCH: AdrSrc=0, IRWrite=1, PCUpdate=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; next DECODE.
REQ-007 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00; next by op: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BRANCH, 1101111->JAL, 1100111->JALR (EXT_JALR), 0110111->LUI (EXT_U), 0010111->ALUWB (EXT_U), else TRAP.
REQ-008 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; next MEMREAD if op=0000011, else MEMWRITE.
REQ-009 MEMREAD: AdrSrc=1, ResultSrc=00; next MEMWB. MEMWB: ResultSrc=01, RegWrite=1; next FETCH.
REQ-010 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1; next FETCH.
REQ-011 EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Both next ALUWB.
REQ-012 ALUWB: ResultSrc=00, RegWrite=1; next FETCH.
REQ-013 BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1; next FETCH.
REQ-014 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1; next ALUWB.
REQ-015 JALR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; next JAL.
REQ-016 LUI: ALUSrcA=11, ALUSrcB=01, ALUOp=00; next ALUWB.
REQ-017 TRAP: illegal=1, all write enables 0; absorbing until reset.
REQ-018 ImmSrc SHALL be combinational from op: 0000011/0010011/1100111 -> 000; 0100011 -> 001; 1100011 -> 010; 1101111 -> 011; 0110111/0010111 -> 100; other -> 000.
REQ-019 instr_done SHALL be 1 in MEMWB, MEMWRITE (on advance), ALUWB, BRANCH; otherwise 0.
REQ-020 MEM_WAIT=1: in FETCH, MEMREAD, MEMWRITE with mem_ready=0 the state SHALL hold; IRWrite, PCUpdate and instr_done gated to 0 while waiting; MemWrite and AdrSrc held asserted; advance on first cycle mem_ready=1.
REQ-021 MEM_WAIT=0: mem_ready SHALL be ignored; each state lasts exactly one cycle.
REQ-022 Latencies (MEM_WAIT=0, FETCH to next FETCH): lw 5, sw 4, R/I 4, branch 3, jal 4, jalr 5, lui 4, auipc 3.
REQ-023 Disabled extension opcodes SHALL decode as illegal (TRAP).

Reset
REQ-024 rst_n=0 SHALL asynchronously force state FETCH; while rst_n=0, RegWrite, MemWrite, IRWrite, PCUpdate, Branch, instr_done, illegal SHALL be 0.
REQ-025 First FETCH outputs SHALL appear on the first clk edge after rst_n rises; reset mid-instruction (any state including TRAP) SHALL abandon it with no write enable asserted afterward until FETCH.

Verification
REQ-026 op=0000011, MEM_WAIT=0 -> FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegWrite=1 only in cycle 5, ResultSrc=01, ImmSrc=000.
REQ-027 op=1100111 -> FETCH,DECODE,JALR,JAL,ALUWB; PCUpdate=1 in cycles 1 and 4; RegWrite=1 in cycle 5.
REQ-028 MEM_WAIT=1, op=0100011, mem_ready=0 for 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles, instr_done=1 only in last.
REQ-029 op=0110111 with EXT_U=0 -> DECODE then TRAP, illegal=1 held for 10 cycles, RegWrite=0.
REQ-030 rst_n dropped asynchronously mid-MEMWRITE -> MemWrite=0 immediately; after release FETCH with IRWrite=1.
